// File: rtl/hamming_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : hamming_frame_tx
// Description : Serial SECDED byte transmitter. Each accepted byte becomes a
//               Hamming(12,8) codeword plus overall parity (13 bits). A frame
//               is sent one bit per clock on serialOut: SYNC_LEN sync bits,
//               then the codeword MSB first, then GAP_LEN idle-low bits.
//               Optional macro HAMMING_TX_ERR_INJECT_EN adds an err_mask input
//               that is XORed into the transmitted codeword.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_frame_tx #(
  parameter int                  SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = 4'b0111,
  parameter int                  GAP_LEN  = 2
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
`ifdef HAMMING_TX_ERR_INJECT_EN
  input  logic [12:0] err_mask,
`endif
  output logic        data_ready,
  output logic        serialOut,
  output logic        busy
);

  // Counter must reach the longest phase length minus one.
  localparam int c_maxLen = (SYNC_LEN > 13)
                          ? ((SYNC_LEN > GAP_LEN) ? SYNC_LEN : GAP_LEN)
                          : ((13 > GAP_LEN) ? 13 : GAP_LEN);
  localparam int c_cntW = (c_maxLen < 2) ? 1 : $clog2(c_maxLen);

  localparam logic [c_cntW-1:0] c_syncLast = c_cntW'(SYNC_LEN - 1);
  localparam logic [c_cntW-1:0] c_dataLast = c_cntW'(12);
  localparam logic [c_cntW-1:0] c_gapLast  = c_cntW'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [c_cntW-1:0]   r_cnt;
  logic [12:0]         r_cw;
  logic [SYNC_LEN-1:0] r_sync;
  logic                r_ready;
  logic                r_busy;

  logic                w_accept;
  logic [12:1]         w_word;
  logic [12:0]         w_cw;
  logic [12:0]         w_mask;

`ifdef HAMMING_TX_ERR_INJECT_EN
  assign w_mask = err_mask;
`else
  assign w_mask = 13'd0;
`endif

  assign w_accept = data_valid && r_ready;

  // Hamming(12,8) placement: data at positions 3,5,6,7,9,10,11,12, parity at
  // 1,2,4,8, each parity covering positions whose index has that bit set.
  always_comb begin
    w_word     = '0;
    w_word[3]  = data_in[0];
    w_word[5]  = data_in[1];
    w_word[6]  = data_in[2];
    w_word[7]  = data_in[3];
    w_word[9]  = data_in[4];
    w_word[10] = data_in[5];
    w_word[11] = data_in[6];
    w_word[12] = data_in[7];
    w_word[1]  = data_in[0] ^ data_in[1] ^ data_in[3] ^ data_in[4] ^ data_in[6];
    w_word[2]  = data_in[0] ^ data_in[2] ^ data_in[3] ^ data_in[5] ^ data_in[6];
    w_word[4]  = data_in[1] ^ data_in[2] ^ data_in[3] ^ data_in[7];
    w_word[8]  = data_in[4] ^ data_in[5] ^ data_in[6] ^ data_in[7];
    w_cw       = {w_word, ^w_word};
  end

  // State register, phase counter, shift registers and registered flags.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cw    <= '0;
      r_sync  <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ready <= (w_nextState == S_IDLE);
      r_busy  <= (w_nextState != S_IDLE);
      // Counter restarts on every phase change; it idles at zero.
      if (w_nextState != r_state)
        r_cnt <= '0;
      else if (r_state != S_IDLE)
        r_cnt <= r_cnt + c_cntW'(1);
      if (w_accept) begin
        r_cw   <= w_cw ^ w_mask;
        r_sync <= SYNC_PAT;
      end else begin
        if (r_state == S_DATA) r_cw   <= r_cw << 1;
        if (r_state == S_SYNC) r_sync <= r_sync << 1;
      end
    end
  end

  // Next-state and serial line selection.
  always_comb begin
    w_nextState = r_state;
    serialOut   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_nextState = S_SYNC;
      end
      S_SYNC: begin
        serialOut = r_sync[SYNC_LEN-1];
        if (r_cnt == c_syncLast) w_nextState = S_DATA;
      end
      S_DATA: begin
        serialOut = r_cw[12];
        if (r_cnt == c_dataLast) w_nextState = S_GAP;
      end
      S_GAP: begin
        if (r_cnt == c_gapLast) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign data_ready = r_ready;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hamming_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_frame_tx
// Description : Self-checking bench for hamming_frame_tx against a reference
//               model that builds each frame from the Hamming placement rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_frame_tx;

  localparam logic [3:0] c_syncPat = 4'b0111;

  logic        clock = 1'b0;
  logic        reset_L = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        data_valid = 1'b0;
  logic [12:0] err_mask = 13'd0;
  logic        data_ready;
  logic        serialOut;
  logic        busy;

  int nVec = 0;
  int nBad = 0;
  int cyc = 0;

  // Captured by capture_frame
  logic [18:0] obs;
  logic        busyAll, readyAny, postReady, postBusy, postSerial;
  logic        timedOut, aborted;
  int          acceptCyc;

  hamming_frame_tx dut (
    .clock      (clock),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .data_valid (data_valid),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .err_mask   (err_mask),
`endif
    .data_ready (data_ready),
    .serialOut  (serialOut),
    .busy       (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference codeword: place data, compute each parity over covered positions.
  function automatic logic [12:0] model_cw(input logic [7:0] d, input logic [12:0] m);
    logic [12:0] cw;
    int dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    int pp;
    logic par;
    cw = '0;
    for (int i = 0; i < 8; i++) cw[dpos[i]] = d[i];
    for (int j = 0; j < 4; j++) begin
      pp = 1 << j;
      par = 1'b0;
      for (int pos = 1; pos <= 12; pos++)
        if (((pos & pp) != 0) && (pos != pp)) par ^= cw[pos];
      cw[pp] = par;
    end
    par = 1'b0;
    for (int pos = 1; pos <= 12; pos++) par ^= cw[pos];
    cw[0] = par;
    return cw ^ m;
  endfunction

  function automatic logic [18:0] model_frame(input logic [7:0] d, input logic [12:0] m);
    return {c_syncPat, model_cw(d, m), 2'b00};
  endfunction

  // Waits for ready, sends one byte, records 19 frame cycles and the cycle after.
  task automatic capture_frame(input logic [7:0] d, input logic [12:0] m, input bit hold,
                               input logic [7:0] nxt, input int pulseAt, input int abortAt);
    int w;
    obs = '0; timedOut = 1'b0; aborted = 1'b0; busyAll = 1'b1; readyAny = 1'b0;
    w = 0;
    while (!data_ready && w < 50) begin step(); w++; end
    if (!data_ready) begin timedOut = 1'b1; return; end
    data_in = d; err_mask = m; data_valid = 1'b1;
    step();
    acceptCyc = cyc;
    if (hold) data_in = nxt;
    else begin data_valid = 1'b0; data_in = 8'($urandom); err_mask = 13'($urandom); end
    for (int k = 0; k < 19; k++) begin
      if (k == abortAt) begin
        reset_L = 1'b0;
        step();
        reset_L = 1'b1;
        aborted = 1'b1;
        postReady = data_ready; postBusy = busy; postSerial = serialOut;
        return;
      end
      obs[18-k] = serialOut;
      busyAll &= busy;
      readyAny |= data_ready;
      if (k == pulseAt) begin data_valid = 1'b1; data_in = 8'($urandom); end
      else if (k == pulseAt + 1) data_valid = 1'b0;
      step();
    end
    postReady = data_ready; postBusy = busy; postSerial = serialOut;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; data_valid = 1'b0;
    step(); step();
    reset_L = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nVec++;
      if (serialOut !== 1'b0 || data_ready !== 1'b1 || busy !== 1'b0) begin
        nBad++;
        $display("FAIL reset_idle cyc%0d: got serial=%b ready=%b busy=%b, want 0 1 0",
                 i, serialOut, data_ready, busy);
      end
      step();
    end
  endtask

  task automatic test_letter_a();
    logic [18:0] lit;
    lit = 19'b0111_0100100001001_00;
    capture_frame(8'h41, 13'd0, 1'b0, 8'd0, -1, -1);
    nVec++;
    if (timedOut) begin nBad++; $display("FAIL letter_a_ready: timed out waiting for data_ready"); end
    nVec++;
    if (obs !== lit) begin nBad++; $display("FAIL letter_a_bits: got %b want %b", obs, lit); end
    nVec++;
    if (obs !== model_frame(8'h41, 13'd0)) begin
      nBad++; $display("FAIL letter_a_model: got %b want %b", obs, model_frame(8'h41, 13'd0));
    end
    nVec++;
    if (busyAll !== 1'b1 || readyAny !== 1'b0) begin
      nBad++; $display("FAIL letter_a_flags: got busyAll=%b readyAny=%b want 1 0", busyAll, readyAny);
    end
    nVec++;
    if (postReady !== 1'b1 || postBusy !== 1'b0 || postSerial !== 1'b0) begin
      nBad++; $display("FAIL letter_a_n20: got ready=%b busy=%b serial=%b want 1 0 0",
                       postReady, postBusy, postSerial);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] obs0;
    int acc0;
    capture_frame(8'h00, 13'd0, 1'b1, 8'hFF, -1, -1);
    obs0 = obs; acc0 = acceptCyc;
    capture_frame(8'hFF, 13'd0, 1'b0, 8'd0, -1, -1);
    nVec++;
    if (timedOut) begin nBad++; $display("FAIL b2b_ready: timed out waiting for data_ready"); end
    nVec++;
    if (acceptCyc - acc0 != 20) begin
      nBad++; $display("FAIL b2b_period: got %0d cycles want 20", acceptCyc - acc0);
    end
    nVec++;
    if (obs0[14:2] !== 13'd0 || obs0 !== model_frame(8'h00, 13'd0)) begin
      nBad++; $display("FAIL b2b_zero_frame: got %b want %b", obs0, model_frame(8'h00, 13'd0));
    end
    nVec++;
    if (obs !== model_frame(8'hFF, 13'd0)) begin
      nBad++; $display("FAIL b2b_ff_frame: got %b want %b", obs, model_frame(8'hFF, 13'd0));
    end
    nVec++;
    if ((^obs[14:2]) !== 1'b0) begin
      nBad++; $display("FAIL b2b_ff_parity: got odd parity cw=%h want even", obs[14:2]);
    end
  endtask

  task automatic test_ignore_midframe();
    logic [7:0] d;
    d = 8'($urandom);
    capture_frame(d, 13'd0, 1'b0, 8'd0, 8, -1);
    nVec++;
    if (obs !== model_frame(d, 13'd0)) begin
      nBad++; $display("FAIL ignore_bits: got %b want %b", obs, model_frame(d, 13'd0));
    end
    nVec++;
    if (postReady !== 1'b1 || postBusy !== 1'b0) begin
      nBad++; $display("FAIL ignore_n20: got ready=%b busy=%b want 1 0", postReady, postBusy);
    end
    step();
    nVec++;
    if (busy !== 1'b0 || serialOut !== 1'b0) begin
      nBad++; $display("FAIL ignore_ghost: got busy=%b serial=%b want 0 0", busy, serialOut);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic [18:0] exp;
    d = 8'($urandom);
    exp = model_frame(d, 13'd0);
    capture_frame(d, 13'd0, 1'b0, 8'd0, -1, 10);
    nVec++;
    if (aborted !== 1'b1 || obs[18:9] !== exp[18:9]) begin
      nBad++; $display("FAIL rstmid_prefix: got %b want %b", obs[18:9], exp[18:9]);
    end
    nVec++;
    if (postSerial !== 1'b0 || postReady !== 1'b1 || postBusy !== 1'b0) begin
      nBad++; $display("FAIL rstmid_after: got serial=%b ready=%b busy=%b want 0 1 0",
                       postSerial, postReady, postBusy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      nVec++;
      if (serialOut !== 1'b0 || busy !== 1'b0) begin
        nBad++; $display("FAIL rstmid_idle: got serial=%b busy=%b want 0 0", serialOut, busy);
      end
    end
    d = 8'($urandom);
    capture_frame(d, 13'd0, 1'b0, 8'd0, -1, -1);
    nVec++;
    if (obs !== model_frame(d, 13'd0)) begin
      nBad++; $display("FAIL rstmid_next: got %b want %b", obs, model_frame(d, 13'd0));
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int idle;
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      idle = $urandom_range(0, 3);
      for (int i = 0; i < idle; i++) step();
      capture_frame(d, 13'd0, 1'b0, 8'd0, -1, -1);
      nVec++;
      if (timedOut || obs !== model_frame(d, 13'd0)) begin
        nBad++; $display("FAIL random_frame d=%h: got %b want %b", d, obs, model_frame(d, 13'd0));
      end
      nVec++;
      if (postReady !== 1'b1 || busyAll !== 1'b1) begin
        nBad++; $display("FAIL random_flags d=%h: got ready=%b busyAll=%b want 1 1",
                         d, postReady, busyAll);
      end
    end
  endtask

`ifdef HAMMING_TX_ERR_INJECT_EN
  task automatic test_err_inject();
    capture_frame(8'h41, 13'h0001, 1'b0, 8'd0, -1, -1);
    nVec++;
    if (obs !== {c_syncPat, 13'h0908, 2'b00}) begin
      nBad++; $display("FAIL inject_1bit: got cw=%h want 0908", obs[14:2]);
    end
    capture_frame(8'h41, 13'h0011, 1'b0, 8'd0, -1, -1);
    nVec++;
    if (obs !== {c_syncPat, 13'h0918, 2'b00}) begin
      nBad++; $display("FAIL inject_2bit: got cw=%h want 0918", obs[14:2]);
    end
    for (int n = 0; n < 4; n++) begin
      logic [7:0] d;
      logic [12:0] m;
      d = 8'($urandom);
      m = 13'($urandom);
      capture_frame(d, m, 1'b0, 8'd0, -1, -1);
      nVec++;
      if (obs !== model_frame(d, m)) begin
        nBad++; $display("FAIL inject_rand d=%h m=%h: got %b want %b", d, m, obs, model_frame(d, m));
      end
    end
    err_mask = 13'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_letter_a();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_random();
`ifdef HAMMING_TX_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hamming_frame_tx.md
Name: hamming_frame_tx

Overview:
- Serial transmitter for the framed single-error-correct, double-error-detect (SECDED) byte link. It is the sending end matched to the link receiver, which frame-syncs, corrects 1-bit errors and flags 2-bit errors.
- Accepts one byte per valid/ready handshake and encodes it to a 13-bit Hamming(12,8)+overall-parity codeword.
- Sends a sync pattern, then the codeword MSB first, then a mandatory idle gap, one bit per clock on serialOut.

Parameters:
- SYNC_LEN, 4, number of sync bits sent before each codeword.
- SYNC_PAT, 4'b0111, sync pattern, sent MSB first; width SYNC_LEN.
- GAP_LEN, 2, idle-low cycles after the codeword before the next byte can be accepted; must be >= 1.

Ports:
- clock, input, 1, system clock; all state changes on posedge.
- reset_L, input, 1, synchronous active-low reset.
- data_in, input, 8, byte to send; sampled only on an accept edge.
- data_valid, input, 1, data_in is valid.
- data_ready, output, 1, block can accept a byte this cycle.
- serialOut, output, 1, serial line; idle value 0.
- busy, output, 1, high while a frame (sync, codeword or gap) is in progress.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (reset_L sampled low at posedge clock resets the block).
  - Reset values: state=IDLE, serialOut=0, data_ready=1, busy=0, counters and shift register cleared.
  - Reset mid-frame aborts the frame; the line is 0 from the next edge. No partial frame resumes.
- Accept: a posedge with data_valid && data_ready latches data_in and encodes it that same edge into register cw[12:0].
- Encoding (positions 1..12 = cw[12:1]):
  - Data bits: d0..d7 at positions 3,5,6,7,9,10,11,12.
  - Parity p1, p2, p4, p8 at positions 1, 2, 4, 8. Each is even parity over positions whose index has that bit set.
  - cw[0] = XOR of cw[12:1], so the overall 13-bit word has even parity.
- States:
  - IDLE: serialOut=0, data_ready=1, busy=0. On accept, go to SYNC.
  - SYNC: serialOut=SYNC_PAT[SYNC_LEN-1-k] for k=0..SYNC_LEN-1. After SYNC_LEN cycles, go to DATA.
  - DATA: serialOut=cw[12-k] for k=0..12 (cw[12] first, cw[0] last). After 13 cycles, go to GAP.
  - GAP: serialOut=0 for GAP_LEN cycles, then go to IDLE.
- data_ready and busy are registered outputs. data_ready=1 only in IDLE; busy=1 in SYNC, DATA and GAP.
- Timing: accept at edge N drives the first sync bit in cycle N+1.
  - Codeword occupies cycles N+5..N+17 (defaults).
  - Gap occupies N+18..N+19; data_ready is high again in cycle N+20.
  - Frame-to-frame period is 1+SYNC_LEN+13+GAP_LEN = 20 cycles when data_valid is held high.
- data_valid while not ready is ignored; data_in changes during a frame do not affect the frame.
- Bit counter wraps/reloads per state; no carry between frames.

Optional Feature:
- Macro: HAMMING_TX_ERR_INJECT_EN.
- Defined:
  - Adds input err_mask[12:0], sampled at the accept edge.
  - The transmitted codeword is cw ^ err_mask; the sync and gap bits are unaffected.
  - Used to drive 1-bit and 2-bit errors into the receiver.
- Undefined: port absent; codeword sent unmodified.

Test Plan:
- Reset low 2 cycles, then high, data_valid=0 for 10 cycles -> serialOut=0, data_ready=1, busy=0 throughout.
- Send 8'h41 ('A') -> serial bits from N+1: 0111 then 0100100001001 (cw=13'h0909), then 00; data_ready high again at N+20.
- Send 8'h00 then 8'hFF with data_valid held high -> back-to-back frames exactly 20 cycles apart. Each codeword has even overall parity; the 8'h00 codeword is all zeros.
- Pulse data_valid with new data during DATA state of a frame -> the pulse is ignored and the in-flight codeword bits are unchanged.
- Assert reset_L=0 for one edge at codeword bit 6 -> serialOut=0 from the next edge, data_ready=1, and the next frame starts cleanly with its sync pattern.
- With HAMMING_TX_ERR_INJECT_EN, send 8'h41 with err_mask=13'h0001 -> codeword 13'h0908. With err_mask=13'h0011 -> codeword 13'h0918; the paired receiver flags a 2-bit error.
